// File: rtl/circuito_jogo_param_if.sv
// Player-facing handshake of the game core: start request and switches in,
// round outcome flags out.
interface circuito_jogo_param_if #(
    parameter int WIDTH = 4
);
    logic             iniciar;
    logic [WIDTH-1:0] chaves;
    logic             pronto;
    logic             acertou;
    logic             errou;

    modport master (
        output iniciar, chaves,
        input  pronto, acertou, errou
    );

    modport slave (
        input  iniciar, chaves,
        output pronto, acertou, errou
    );
endinterface

// File: rtl/circuito_jogo_param.sv
// Sequence memory game core: walks a one-hot ROM and compares each player move
// against it, stopping on the first mismatch or after the last entry matches.
module circuito_jogo_param #(
    parameter int WIDTH      = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    circuito_jogo_param_if.slave      jogo,
    output logic                      db_igual,
    output logic                      db_iniciar,
    output logic                      db_tem_jogada,
    output logic [ADDR_WIDTH-1:0]     db_contagem,
    output logic [WIDTH-1:0]          db_memoria,
    output logic [WIDTH-1:0]          db_jogada,
    output logic [3:0]                db_estado
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [WIDTH-1:0]      ONE  = WIDTH'(1);

    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARACAO  = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] REGISTRA    = 4'h4;
    localparam logic [3:0] COMPARACAO  = 4'h5;
    localparam logic [3:0] PROXIMO     = 4'h6;
    localparam logic [3:0] FIM_ACERTO  = 4'hA;
    localparam logic [3:0] FIM_ERRO    = 4'hE;

    logic [3:0]            estado_q, estado_d;
    logic [ADDR_WIDTH-1:0] contador_q, contador_d;
    logic [WIDTH-1:0]      jogada_q, jogada_d;
    logic [WIDTH-1:0]      chaves_ant_q;
    logic [WIDTH-1:0]      memoria;
    logic                  tem_jogada;
    logic                  igual;
    int                    rom_idx;

    // ROM word i is a single bit walking across the switches.
    always_comb begin
        rom_idx = int'(contador_q) % WIDTH;
        memoria = ONE << rom_idx;
    end

    // Only an all-zero to non-zero transition counts as a new move.
    assign tem_jogada = (jogo.chaves != '0) && (chaves_ant_q == '0);
    assign igual      = (jogada_q == memoria);

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        jogada_d   = jogada_q;
        case (estado_q)
            INICIAL: begin
                if (jogo.iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                contador_d = '0;
                jogada_d   = '0;
                estado_d   = ESPERA;
            end
            ESPERA: begin
                if (tem_jogada) estado_d = REGISTRA;
            end
            REGISTRA: begin
                jogada_d = jogo.chaves;
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual)                  estado_d = FIM_ERRO;
                else if (contador_q == LAST) estado_d = FIM_ACERTO;
                else                         estado_d = PROXIMO;
            end
            PROXIMO: begin
                contador_d = contador_q + ADDR_WIDTH'(1);
                estado_d   = ESPERA;
            end
            FIM_ACERTO, FIM_ERRO: begin
                if (jogo.iniciar) estado_d = PREPARACAO;
            end
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            contador_q   <= '0;
            jogada_q     <= '0;
            chaves_ant_q <= '0;
        end else begin
            estado_q     <= estado_d;
            contador_q   <= contador_d;
            jogada_q     <= jogada_d;
            chaves_ant_q <= jogo.chaves;
        end
    end

    assign jogo.pronto  = (estado_q == FIM_ACERTO) || (estado_q == FIM_ERRO);
    assign jogo.acertou = (estado_q == FIM_ACERTO);
    assign jogo.errou   = (estado_q == FIM_ERRO);

    assign db_igual      = igual;
    assign db_iniciar    = jogo.iniciar;
    assign db_tem_jogada = tem_jogada;
    assign db_contagem   = contador_q;
    assign db_memoria    = memoria;
    assign db_jogada     = jogada_q;
    assign db_estado     = estado_q;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// Directed bench for the game core: default 4x16 instance plus a 2x4 instance,
// covering reset, full success, early error, held switches and restart.
module tb_circuito_jogo_param;

    logic clock;
    logic reset;
    int   numCompared;
    int   numMismatched;

    circuito_jogo_param_if #(.WIDTH(4)) busA ();
    circuito_jogo_param_if #(.WIDTH(2)) busB ();

    logic       igualA, iniciarDbA, temJogadaA;
    logic [3:0] contagemA, memoriaA, jogadaA, estadoA;
    logic       igualB, iniciarDbB, temJogadaB;
    logic [1:0] contagemB, memoriaB, jogadaB;
    logic [3:0] estadoB;

    circuito_jogo_param #(.WIDTH(4), .ADDR_WIDTH(4)) dutA (
        .clock(clock), .reset(reset), .jogo(busA.slave),
        .db_igual(igualA), .db_iniciar(iniciarDbA), .db_tem_jogada(temJogadaA),
        .db_contagem(contagemA), .db_memoria(memoriaA), .db_jogada(jogadaA),
        .db_estado(estadoA)
    );

    circuito_jogo_param #(.WIDTH(2), .ADDR_WIDTH(2)) dutB (
        .clock(clock), .reset(reset), .jogo(busB.slave),
        .db_igual(igualB), .db_iniciar(iniciarDbB), .db_tem_jogada(temJogadaB),
        .db_contagem(contagemB), .db_memoria(memoriaB), .db_jogada(jogadaB),
        .db_estado(estadoB)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One iniciar pulse; returns on the falling edge after the core reaches espera.
    task automatic pulseIniciar(input int sel);
        @(negedge clock);
        if (sel == 0) busA.iniciar = 1'b1; else busB.iniciar = 1'b1;
        @(negedge clock);
        busA.iniciar = 1'b0;
        busB.iniciar = 1'b0;
        @(negedge clock);
    endtask

    // Move held for two cycles, then switches released for two cycles.
    task automatic applyStimulus(input int sel, input logic [3:0] move);
        if (sel == 0) busA.chaves = move; else busB.chaves = move[1:0];
        repeat (2) @(negedge clock);
        busA.chaves = '0;
        busB.chaves = '0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic [3:0] walk;
        numCompared   = 0;
        numMismatched = 0;
        reset         = 1'b0;
        busA.iniciar  = 1'b0;
        busA.chaves   = '0;
        busB.iniciar  = 1'b0;
        busB.chaves   = '0;
        #12 reset = 1'b1;
        @(negedge clock);

        // Reset in the middle of a round
        pulseIniciar(0);
        applyStimulus(0, 4'b0001);
        checkOutput("preResetCount", 32'(contagemA), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rstPronto",   32'(busA.pronto),  32'd0);
        checkOutput("rstAcertou",  32'(busA.acertou), 32'd0);
        checkOutput("rstErrou",    32'(busA.errou),   32'd0);
        checkOutput("rstEstado",   32'(estadoA),      32'h0);
        checkOutput("rstContagem", 32'(contagemA),    32'd0);
        checkOutput("rstMemoria",  32'(memoriaA),     32'b0001);
        checkOutput("rstIgual",    32'(igualA),       32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Full sixteen-move success
        pulseIniciar(0);
        checkOutput("espAfterStart", 32'(estadoA), 32'h2);
        for (int i = 0; i < 16; i++) begin
            walk = 4'b0001 << (i % 4);
            applyStimulus(0, walk);
        end
        checkOutput("okAcertou",  32'(busA.acertou), 32'd1);
        checkOutput("okPronto",   32'(busA.pronto),  32'd1);
        checkOutput("okErrou",    32'(busA.errou),   32'd0);
        checkOutput("okEstado",   32'(estadoA),      32'hA);
        checkOutput("okContagem", 32'(contagemA),    32'd15);

        // Wrong third move
        pulseIniciar(0);
        checkOutput("restartAcertou", 32'(busA.acertou), 32'd0);
        applyStimulus(0, 4'b0001);
        applyStimulus(0, 4'b0010);
        applyStimulus(0, 4'b0001);
        checkOutput("errErrou",    32'(busA.errou),   32'd1);
        checkOutput("errPronto",   32'(busA.pronto),  32'd1);
        checkOutput("errAcertou",  32'(busA.acertou), 32'd0);
        checkOutput("errContagem", 32'(contagemA),    32'd2);
        checkOutput("errJogada",   32'(jogadaA),      32'b0001);
        checkOutput("errMemoria",  32'(memoriaA),     32'b0100);
        checkOutput("errEstado",   32'(estadoA),      32'hE);

        // Restart from fim_erro, then iniciar pulses that espera must ignore
        pulseIniciar(0);
        checkOutput("rsErrou",    32'(busA.errou),  32'd0);
        checkOutput("rsPronto",   32'(busA.pronto), 32'd0);
        checkOutput("rsContagem", 32'(contagemA),   32'd0);
        checkOutput("rsEstado",   32'(estadoA),     32'h2);
        busA.iniciar = 1'b1;
        #1 checkOutput("dbIniciar", 32'(iniciarDbA), 32'd1);
        @(negedge clock);
        busA.iniciar = 1'b0;
        pulseIniciar(0);
        checkOutput("ignEstado",   32'(estadoA),   32'h2);
        checkOutput("ignContagem", 32'(contagemA), 32'd0);

        // Held switches and a direct non-zero to non-zero change
        busA.chaves = 4'b0001;
        #1 checkOutput("temJogadaEdge", 32'(temJogadaA), 32'd1);
        repeat (8) @(negedge clock);
        busA.chaves = 4'b0010;
        #1 checkOutput("temJogadaHeld", 32'(temJogadaA), 32'd0);
        repeat (4) @(negedge clock);
        checkOutput("heldContagem", 32'(contagemA), 32'd1);
        checkOutput("heldEstado",   32'(estadoA),   32'h2);
        checkOutput("heldJogada",   32'(jogadaA),   32'b0001);
        busA.chaves = '0;
        @(negedge clock);

        // Narrow instance: full round of four moves
        pulseIniciar(1);
        applyStimulus(1, 4'b0001);
        applyStimulus(1, 4'b0010);
        applyStimulus(1, 4'b0001);
        applyStimulus(1, 4'b0010);
        checkOutput("bAcertou",  32'(busB.acertou), 32'd1);
        checkOutput("bContagem", 32'(contagemB),    32'd3);
        checkOutput("bEstado",   32'(estadoB),      32'hA);

        // Second round: reset lands during move 2, between clock edges
        pulseIniciar(1);
        applyStimulus(1, 4'b0001);
        busB.chaves = 2'b10;
        @(posedge clock);
        #2;
        checkOutput("bRegistra", 32'(estadoB), 32'h4);
        reset = 1'b0;
        #1;
        checkOutput("bRstEstado",   32'(estadoB),      32'h0);
        checkOutput("bRstContagem", 32'(contagemB),    32'd0);
        checkOutput("bRstAcertou",  32'(busB.acertou), 32'd0);
        checkOutput("bRstMemoria",  32'(memoriaB),     32'b01);
        busB.chaves = '0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule

// File: doc/circuito_jogo_param.md
# circuito_jogo_param

Parametrised successor of the single-round switch/memory comparison circuit. Walks an internal sequence ROM of `2**ADDR_WIDTH` entries. For each entry it waits for one player move on `chaves`, registers it and compares it with the ROM word. It stops on the first mismatch (`errou`) or after the last entry matches (`acertou`). Top-level game core; drives debug ports for the board displays.

## Interface
- `WIDTH`, 4, width of `chaves` and of each ROM word
- `ADDR_WIDTH`, 4, counter/ROM address width; DEPTH = 2**ADDR_WIDTH
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low; `reset`=0 forces the initial state immediately
- `iniciar`  in  1  start/restart request, level sampled on clock edge
- `chaves`  in  WIDTH  player switches
- `pronto`  out  1  round finished (either outcome)
- `acertou`  out  1  whole sequence matched
- `errou`  out  1  mismatch detected
- `db_igual`  out  1  combinational: jogada register == ROM[contador]
- `db_iniciar`  out  1  passthrough of `iniciar`
- `db_tem_jogada`  out  1  move-detect pulse
- `db_contagem`  out  ADDR_WIDTH  current address
- `db_memoria`  out  WIDTH  ROM[contador]
- `db_jogada`  out  WIDTH  registered move
- `db_estado`  out  4  state code

## Operation
- ROM is fixed and combinational: `ROM[i] = 1 << (i mod WIDTH)`. For WIDTH=4 the words are 0001, 0010, 0100, 1000, repeating.
- Move detect:
  - `chaves_ant` register captures `chaves` every cycle; reset value 0.
  - `tem_jogada = (chaves != 0) && (chaves_ant == 0)`.
  - Only a transition from all-zero to non-zero counts as a move.
  - Holding the switches, or changing from one non-zero value to another, gives no new move.
- States (`db_estado` code in parentheses):
  - inicial (0): `iniciar`=1 -> preparacao.
  - preparacao (1): clear contador, jogada, acertou and errou -> espera. Takes 1 cycle.
  - espera (2): `tem_jogada`=1 -> registra; otherwise stay.
  - registra (4): load `chaves` into jogada -> comparacao.
  - comparacao (5):
    - `!db_igual` -> fim_erro.
    - else if contador == DEPTH-1 -> fim_acerto.
    - else -> proximo.
  - proximo (6): contador++ -> espera.
  - fim_acerto (A) / fim_erro (E): hold all outputs. `iniciar`=1 -> preparacao.
  - Unused codes -> inicial.
- `iniciar` is ignored in espera, registra, comparacao and proximo.
- Outputs are Moore:
  - `pronto` = 1 in fim_acerto and fim_erro.
  - `acertou` = 1 in fim_acerto only.
  - `errou` = 1 in fim_erro only.
- Counter stays in 0..DEPTH-1. It never wraps during a round because comparacao exits at DEPTH-1.
- Reset (`reset`=0), including mid-round, asynchronously gives:
  - state inicial; contador, jogada and chaves_ant = 0.
  - `pronto`, `acertou`, `errou` = 0; `db_estado` = 0.
  - `db_memoria` = ROM[0] = 1; `db_igual` = 0.
  - Operation resumes on the first clock edge after `reset` returns to 1.

## Timing
- Move applied before edge k while in espera:
  - Edge k: enters registra.
  - Edge k+1: jogada loaded, enters comparacao.
  - Edge k+2: enters fim_erro / fim_acerto / proximo.
  - Edge k+3: proximo -> espera, with the incremented address visible.
- Minimum per-move loop: 4 cycles. The bench releases `chaves` to 0 for at least 1 cycle between moves.
- `iniciar` pulse of 1 cycle in inicial or fim_*: preparacao after 1 edge, espera after 2 edges.
- A move arriving while not in espera is lost. It is not queued, since `chaves_ant` still tracks it.

## Test plan
1. Reset: drive `reset`=0 mid-simulation -> `pronto`=`acertou`=`errou`=0, `db_estado`=0, `db_contagem`=0, `db_memoria`=0001, `db_igual`=0.
2. Full success, WIDTH=4, ADDR_WIDTH=4:
   - Stimulus: `iniciar` pulse, then 16 moves 0001, 0010, 0100, 1000 repeated, each held 2 cycles then 0000 for 2 cycles.
   - Response: `acertou`=1, `pronto`=1, `errou`=0, `db_estado`=A, `db_contagem`=15.
3. Error on third move:
   - Stimulus: moves 0001, 0010, 0001.
   - Response: `errou`=1, `pronto`=1, `db_contagem`=2, `db_jogada`=0001, `db_memoria`=0100, `db_estado`=E.
4. Held switches:
   - Stimulus: 0001 held for 8 cycles, then 0010 directly with no zero in between.
   - Response: exactly one move registered; `db_contagem`=1; FSM stays in espera (2).
5. Restart and ignore:
   - Stimulus: `iniciar` pulse from fim_erro; then `iniciar` pulses while in espera.
   - Response: after restart `errou`=0, `pronto`=0, `db_contagem`=0, `db_estado`=2; the espera pulses have no effect.
6. Parametric instance WIDTH=2, ADDR_WIDTH=2:
   - Stimulus: moves 01, 10, 01, 10.
   - Response: `acertou`=1 after 4 moves, `db_contagem`=3.
   - Then `reset`=0 during the second round's move 2 -> state 0 immediately, with no clock edge required.
